// File: rtl/sb_pkg.sv
// Shared sideband link definitions used by the transmitter and the receiver.
package sb_pkg;

    localparam int unsigned SB_MSG_BITS  = 64;
    localparam int unsigned SB_GAP_UI    = 32;
    localparam int unsigned SB_BIT_CNT_W = $clog2(SB_MSG_BITS);
    localparam int unsigned SB_GAP_CNT_W = $clog2(SB_GAP_UI);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sb_tx_state_t;

endpackage

// File: rtl/sb_tx_fifo.sv
// Message FIFO for the sideband transmitter: wrapping indices plus an occupancy count.
module sb_tx_fifo
    import sb_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 4
) (
    input  logic                   clk_800MHz,
    input  logic                   reset,
    input  logic                   push,
    input  logic [SB_MSG_BITS-1:0] push_data,
    input  logic                   pop,
    output logic [SB_MSG_BITS-1:0] rd_data_c,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned IDX_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [SB_MSG_BITS-1:0] mem [BUFFER_SIZE];
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic [CNT_W-1:0]       count;
    logic                   push_ok;
    logic                   pop_ok;

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_ok   = push && !full_c;
    assign pop_ok    = pop && !empty_c;
    assign full_c    = (count == CNT_W'(BUFFER_SIZE));
    assign empty_c   = (count == '0);
    assign rd_data_c = mem[rd_idx];

    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_idx <= wr_idx + IDX_W'(1);
            if (pop_ok)  rd_idx <= rd_idx + IDX_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_800MHz) begin
        if (push_ok) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/sb_tx.sv
// Sideband transmitter: serialises queued 64-bit messages LSB-first with a
// forwarded clock, each followed by a 32-UI gap.
module sb_tx
    import sb_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 4
) (
    input  logic                   clk_800MHz,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [SB_MSG_BITS-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   dataPin_o,
    output logic                   clkPin_o,
    output logic                   busy_o
);

    sb_tx_state_t            state;
    logic [SB_MSG_BITS-1:0]  shreg;
    logic [SB_BIT_CNT_W-1:0] bit_cnt;
    logic [SB_GAP_CNT_W-1:0] gap_cnt;
    logic                    phase;

    logic                    fifo_full_c;
    logic                    fifo_empty_c;
    logic [SB_MSG_BITS-1:0]  fifo_data_c;
    logic                    last_gap_c;
    logic                    start_c;

    sb_tx_fifo #(
        .BUFFER_SIZE(BUFFER_SIZE)
    ) u_fifo (
        .clk_800MHz(clk_800MHz),
        .reset     (reset),
        .push      (valid_i),
        .push_data (data_i),
        .pop       (start_c),
        .rd_data_c (fifo_data_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    assign ready_o = !fifo_full_c;

    // A new frame starts from IDLE or straight out of the final gap phase so the clock never stalls.
    assign last_gap_c = (state == GAP) && phase && (gap_cnt == SB_GAP_CNT_W'(SB_GAP_UI - 1));
    assign start_c    = enable_i && !fifo_empty_c && ((state == IDLE) || last_gap_c);

    // Phase 0 drives clkPin high with fresh data; phase 1 drops it so the receiver samples on the fall.
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            phase     <= 1'b0;
            dataPin_o <= 1'b0;
            clkPin_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else if (start_c) begin
            state     <= SEND;
            shreg     <= fifo_data_c;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            phase     <= 1'b0;
            dataPin_o <= fifo_data_c[0];
            clkPin_o  <= 1'b1;
            busy_o    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    phase     <= 1'b0;
                    dataPin_o <= 1'b0;
                    clkPin_o  <= 1'b0;
                    busy_o    <= 1'b0;
                end
                SEND: begin
                    if (!phase) begin
                        phase    <= 1'b1;
                        clkPin_o <= 1'b0;
                    end else begin
                        phase    <= 1'b0;
                        clkPin_o <= 1'b1;
                        if (bit_cnt == SB_BIT_CNT_W'(SB_MSG_BITS - 1)) begin
                            state     <= GAP;
                            gap_cnt   <= '0;
                            dataPin_o <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + SB_BIT_CNT_W'(1);
                            shreg     <= shreg >> 1;
                            dataPin_o <= shreg[1];
                        end
                    end
                end
                GAP: begin
                    dataPin_o <= 1'b0;
                    if (!phase) begin
                        phase    <= 1'b1;
                        clkPin_o <= 1'b0;
                    end else if (gap_cnt == SB_GAP_CNT_W'(SB_GAP_UI - 1)) begin
                        state    <= IDLE;
                        phase    <= 1'b0;
                        clkPin_o <= 1'b0;
                        busy_o   <= 1'b0;
                    end else begin
                        gap_cnt  <= gap_cnt + SB_GAP_CNT_W'(1);
                        phase    <= 1'b0;
                        clkPin_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase     <= 1'b0;
                    dataPin_o <= 1'b0;
                    clkPin_o  <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sb_tx.md
SB_TX -- requirements
Module: sb_tx

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 4, message FIFO depth; power of 2, >1.
REQ-002 SHALL have clk_800MHz  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high.
REQ-004 SHALL have enable_i  input  1  permits starting new messages.
REQ-005 SHALL have data_i  input  64  message to send, bit 0 transmitted first.
REQ-006 SHALL have valid_i  input  1  data_i present; written when valid_i && ready_o.
REQ-007 SHALL have ready_o  output  1  FIFO not full.
REQ-008 SHALL have dataPin_o  output  1  serial data to link.
REQ-009 SHALL have clkPin_o  output  1  forwarded serial clock to link.
REQ-010 SHALL have busy_o  output  1  high while in SEND or GAP.

Function
REQ-011 SHALL hold incoming messages in a BUFFER_SIZE-entry FIFO with wrapping read/write indices plus a count (or extra index bit) to distinguish full from empty.
REQ-012 SHALL drive ready_o = !full, combinationally from registered FIFO state; valid_i while ready_o=0 SHALL be ignored and the word dropped, FIFO unchanged.
REQ-013 SHALL accept writes regardless of enable_i.
REQ-014 SHALL implement FSM states IDLE, SEND, GAP.
REQ-015 SHALL define one UI as 2 clk_800MHz cycles: phase 0 clkPin_o=1, phase 1 clkPin_o=0; dataPin_o changes only entering phase 0 and is stable for both phases, so the receiver samples on the clkPin falling edge.
REQ-016 IDLE: clkPin_o=0, dataPin_o=0; if enable_i && FIFO non-empty, SHALL pop head into a 64-bit shift register, drive clkPin_o=1, dataPin_o=bit 0 on the same edge, and enter SEND.
REQ-017 Latency: word written into empty FIFO at edge N while IDLE and enabled SHALL give clkPin_o=1 with bit 0 after edge N+1.
REQ-018 SEND: SHALL emit 64 UIs (128 cycles), bits 0..63 in order, using a 6-bit bit counter and 1-bit phase; after phase 1 of bit 63 SHALL enter GAP.
REQ-019 GAP: SHALL emit 32 UIs (64 cycles) with clkPin_o toggling per REQ-015 and dataPin_o=0, using a 5-bit counter.
REQ-020 At end of GAP: if enable_i && FIFO non-empty, SHALL pop and begin the next SEND on the next edge with no extra idle cycle (clkPin_o continuous); else SHALL enter IDLE.
REQ-021 Deasserting enable_i mid-SEND or mid-GAP SHALL NOT truncate; the current message and its gap complete, then IDLE.
REQ-022 Simultaneous push and pop SHALL both take effect; count unchanged; push while full is refused even if a pop occurs that cycle.
REQ-023 busy_o SHALL be 1 in SEND and GAP, 0 in IDLE.
REQ-024 All outputs except ready_o SHALL be registered.

Reset
REQ-025 Reset SHALL force IDLE immediately, clear FIFO indices/count, shift register and counters; dataPin_o=0, clkPin_o=0, busy_o=0, ready_o=1.
REQ-026 Reset mid-message SHALL abort it with no further clkPin_o edges; the partial frame is discarded.

Structure
REQ-027 Package sb_pkg SHALL hold state enum sb_tx_state_t, SB_MSG_BITS=64, SB_GAP_UI=32, shared with the sideband receiver.
REQ-028 FIFO SHALL be a sub-module sb_tx_fifo (push/pop/full/empty/data), parameterised by BUFFER_SIZE.

Verification
REQ-029 Single word 64'hA5A5_0000_FFFF_1234 into idle block -> clkPin_o high after 1 cycle; 64 falling edges sampled LSB-first reconstruct the word; then 32 gap UIs with dataPin_o=0; busy_o high 192 cycles.
REQ-030 Write 4 words back-to-back (BUFFER_SIZE=4), 5th while full -> ready_o low, 5th dropped; 4 frames sent contiguously, each 64+32 UI, clkPin_o never idle between frames.
REQ-031 Loopback to the team's sideband receiver, 10 random words -> receiver delivers the identical sequence.
REQ-032 enable_i dropped at bit 20 of a frame with 2 queued -> current frame and gap complete, then IDLE with 2 words retained; re-enable -> both sent.
REQ-033 Reset asserted at bit 40 -> clkPin_o, dataPin_o, busy_o 0 immediately, ready_o=1, FIFO empty; post-reset word 64'h1 sent correctly.
REQ-034 Push and pop same cycle at count 3 -> count stays 3, order preserved.
